period_meter: RTL and testbench
===============================

Name: period_meter

Overview:
- Measures an incoming slow periodic signal, such as a clock_divider output, in units of the system clock.
- Reports the period (rising edge to rising edge) and the high time (rising edge to falling edge) of that signal.
- Flags loss of signal after a programmable number of cycles with no rising edge.
- Sits on the receive/check side of divided or external clocks; used on boards and in benches to confirm divider ratios and duty cycle.

Parameters:
- COUNT_WIDTH, 16, width of the cycle counter and of the period/high_time outputs.
- TIMEOUT, 16'hFFFF, number of clk cycles without a rising edge before timeout is raised; must be ≤ 2^COUNT_WIDTH-1 and ≥ 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  measurement enable, synchronous to clk.
- sig_in  input  1  signal under test, asynchronous to clk.
- period  output  COUNT_WIDTH  last measured period in clk cycles.
- high_time  output  COUNT_WIDTH  last measured high time in clk cycles.
- valid  output  1  one-cycle pulse when period/high_time update.
- timeout  output  1  sticky loss-of-signal flag.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n). While rst_n=0:
  - period=0, high_time=0, valid=0, timeout=0.
  - Both synchroniser flops = 0, edge-history flop = 0, cnt=0, hi=0, state=IDLE.
- Synchroniser and edge detect:
  - sig_in passes through 2 flops to give s; s_d is s delayed by one cycle.
  - rise = s & ~s_d; fall = ~s & s_d.
  - An edge on sig_in is seen 2-3 clk cycles later; this latency is identical for both edges, so it does not affect measured values.
- States:
  - IDLE: cnt=0. Goes to ARMED when en=1.
  - ARMED: waits for the first rise. On rise: cnt<=1, go to MEASURE, no valid. The first partial period is discarded.
  - MEASURE, on a rise cycle:
    - period<=cnt, high_time<=hi, valid<=1 (one cycle), cnt<=1, timeout<=0.
  - MEASURE, on a fall cycle: hi<=cnt, cnt<=cnt+1.
  - MEASURE, other cycles: cnt<=cnt+1.
  - MEASURE, timeout exit: when cnt==TIMEOUT with no rise in that cycle, timeout<=1, cnt<=0, go to ARMED. No valid is produced.
- en=0 in any state:
  - Next state is IDLE, cnt<=0, hi<=0, valid<=0.
  - period, high_time and timeout hold their values.
  - An in-progress measurement is discarded.
- Simultaneous events:
  - A rise in the same cycle as cnt==TIMEOUT counts as a rise, not a timeout.
  - en=0 takes priority over rise and over timeout.
- Arithmetic:
  - cnt never exceeds TIMEOUT, so there is no wrap-around.
  - A reported period is always ≥ 2; high_time is always ≥ 1 and < period.
- valid is never asserted on two consecutive cycles (minimum period 2).
- timeout stays at 1 through ARMED and clears only on the next valid measurement or on reset.

Test Plan:
- sig_in 6-cycle period, 3 high / 3 low, en=1 → first valid at the 2nd detected rise; every later valid shows period=6, high_time=3, spaced 6 cycles apart, timeout=0.
- sig_in 10-cycle period, 2 high / 8 low, then switched to a 4-cycle period, 1 high → valids show 10/2, then one 4-cycle-based measurement, then steady 4/1.
- TIMEOUT=20, sig_in held low after locking on 6/3 → timeout=1 exactly 20 cycles after the last rise, period/high_time hold 6/3, no valid. Restart 6/3 → timeout stays 1 until the first new valid, then 0.
- en dropped mid-period while locked on 8/4 → no valid. Re-enable → first rise discarded, next valid shows 8/4.
- rst_n pulsed low for 1 ns mid-measurement, asynchronous to clk → all outputs 0 immediately. After release, state is IDLE and the ARMED sequence repeats.
- TIMEOUT=6 with sig_in period exactly 6 → rise wins every cycle; valid shows period=6, timeout never asserts.

Source files
------------

// File: rtl/period_meter.sv
// Measures period and high time of a slow signal in clk cycles; sticky loss-of-signal flag.
// Edges seen 2-3 cycles after sig_in; valid pulses one cycle after each rise; no backpressure.
module period_meter #(
    parameter int COUNT_WIDTH = 16,
    parameter int TIMEOUT     = 16'hFFFF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   sig_in,
    output logic [COUNT_WIDTH-1:0] period,
    output logic [COUNT_WIDTH-1:0] high_time,
    output logic                   valid,
    output logic                   timeout
);

    localparam logic [COUNT_WIDTH-1:0] TIMEOUT_CNT = COUNT_WIDTH'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   sync1;
    logic                   s;
    logic                   s_d;
    logic                   rise;
    logic                   fall;
    logic                   at_limit;
    logic [COUNT_WIDTH-1:0] cnt;
    logic [COUNT_WIDTH-1:0] hi;
    logic [COUNT_WIDTH-1:0] cnt_nxt;
    logic [COUNT_WIDTH-1:0] hi_nxt;
    logic [COUNT_WIDTH-1:0] period_nxt;
    logic [COUNT_WIDTH-1:0] high_time_nxt;
    logic                   valid_nxt;
    logic                   timeout_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
            s_d   <= 1'b0;
        end else begin
            sync1 <= sig_in;
            s     <= sync1;
            s_d   <= s;
        end
    end

    assign rise     = s & ~s_d;
    assign fall     = ~s & s_d;
    assign at_limit = (cnt == TIMEOUT_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = ARMED;
                ARMED:   if (rise) state_nxt = MEASURE;
                MEASURE: if (!rise && at_limit) state_nxt = ARMED;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Priority: en low, then rise, then timeout, then fall; a rise on the limit cycle is a measurement.
    always_comb begin
        cnt_nxt       = cnt;
        hi_nxt        = hi;
        period_nxt    = period;
        high_time_nxt = high_time;
        valid_nxt     = 1'b0;
        timeout_nxt   = timeout;
        if (!en) begin
            cnt_nxt = '0;
            hi_nxt  = '0;
        end else begin
            case (state)
                IDLE: cnt_nxt = '0;
                ARMED: begin
                    if (rise) cnt_nxt = COUNT_WIDTH'(1);
                end
                MEASURE: begin
                    if (rise) begin
                        period_nxt    = cnt;
                        high_time_nxt = hi;
                        valid_nxt     = 1'b1;
                        cnt_nxt       = COUNT_WIDTH'(1);
                        timeout_nxt   = 1'b0;
                    end else if (at_limit) begin
                        timeout_nxt = 1'b1;
                        cnt_nxt     = '0;
                    end else begin
                        cnt_nxt = cnt + COUNT_WIDTH'(1);
                        if (fall) hi_nxt = cnt;
                    end
                end
                default: cnt_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            hi        <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            hi        <= hi_nxt;
            period    <= period_nxt;
            high_time <= high_time_nxt;
            valid     <= valid_nxt;
            timeout   <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: directed waveforms push expected results, a monitor pops on valid.
module tb_period_meter;

    localparam int CW = 16;

    typedef struct {
        int per;
        int hi;
        int to;
        int gap;
    } exp_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          en_a  = 1'b0;
    logic          sig_a = 1'b0;
    logic          en_b  = 1'b0;
    logic          sig_b = 1'b0;
    logic [CW-1:0] period_a;
    logic [CW-1:0] high_a;
    logic [CW-1:0] period_b;
    logic [CW-1:0] high_b;
    logic          valid_a;
    logic          timeout_a;
    logic          valid_b;
    logic          timeout_b;

    int   tests     = 0;
    int   failed    = 0;
    int   cyc       = 0;
    int   last_a    = 0;
    int   last_b    = 0;
    int   to_rise_a = 0;
    int   to_seen_b = 0;
    logic to_prev_a = 1'b0;
    bit   guard_b   = 1'b0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a;
    exp_t e_b;

    always #5 clk = ~clk;

    period_meter #(.COUNT_WIDTH(CW), .TIMEOUT(20)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en_a),
        .sig_in    (sig_a),
        .period    (period_a),
        .high_time (high_a),
        .valid     (valid_a),
        .timeout   (timeout_a)
    );

    period_meter #(.COUNT_WIDTH(CW), .TIMEOUT(6)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en_b),
        .sig_in    (sig_b),
        .period    (period_b),
        .high_time (high_b),
        .valid     (valid_b),
        .timeout   (timeout_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic gen_a(input int h, input int l, input int n);
        for (int i = 0; i < n; i++) begin
            sig_a = 1'b1;
            tick(h);
            sig_a = 1'b0;
            tick(l);
        end
    endtask

    task automatic gen_b(input int h, input int l, input int n);
        for (int i = 0; i < n; i++) begin
            sig_b = 1'b1;
            tick(h);
            sig_b = 1'b0;
            tick(l);
        end
    endtask

    task automatic push_a(input int per, input int hi, input int to, input int gap);
        exp_t e;
        e.per = per; e.hi = hi; e.to = to; e.gap = gap;
        q_a.push_back(e);
    endtask

    task automatic push_b(input int per, input int hi, input int to, input int gap);
        exp_t e;
        e.per = per; e.hi = hi; e.to = to; e.gap = gap;
        q_b.push_back(e);
    endtask

    // Monitor: gap of 0 means the spacing from the previous valid is not checked.
    always @(negedge clk) begin
        cyc++;
        if (valid_a) begin
            check("a_valid_expected", 32'(q_a.size() > 0), 32'd1);
            if (q_a.size() > 0) begin
                e_a = q_a.pop_front();
                check("a_period", 32'(period_a), e_a.per);
                check("a_high_time", 32'(high_a), e_a.hi);
                check("a_timeout_at_valid", 32'(timeout_a), e_a.to);
                if (e_a.gap != 0) check("a_valid_gap", cyc - last_a, e_a.gap);
            end
            last_a = cyc;
        end
        if (timeout_a && !to_prev_a) begin
            check("a_timeout_delay", cyc - last_a, 20);
            to_rise_a++;
        end
        to_prev_a = timeout_a;
        if (valid_b) begin
            check("b_valid_expected", 32'(q_b.size() > 0), 32'd1);
            if (q_b.size() > 0) begin
                e_b = q_b.pop_front();
                check("b_period", 32'(period_b), e_b.per);
                check("b_high_time", 32'(high_b), e_b.hi);
                check("b_timeout_at_valid", 32'(timeout_b), e_b.to);
                if (e_b.gap != 0) check("b_valid_gap", cyc - last_b, e_b.gap);
            end
            last_b = cyc;
        end
        if (guard_b && timeout_b) to_seen_b++;
    end

    initial begin
        #100000;
        failed++;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        #2;
        check("rst_period", 32'(period_a), 32'd0);
        check("rst_high_time", 32'(high_a), 32'd0);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_timeout", 32'(timeout_a), 32'd0);
        #20;
        rst_n = 1'b1;
        tick(2);

        // 6-cycle, 50% duty; then loss of signal with TIMEOUT=20
        en_a = 1'b1;
        tick(3);
        push_a(6, 3, 0, 0);
        for (int i = 0; i < 3; i++) push_a(6, 3, 0, 6);
        gen_a(3, 3, 5);
        tick(30);
        check("lost_timeout", 32'(timeout_a), 32'd1);
        check("lost_period_hold", 32'(period_a), 32'd6);
        check("lost_high_hold", 32'(high_a), 32'd3);
        check("lost_timeout_rises", to_rise_a, 32'd1);
        check("lost_queue_drained", q_a.size(), 32'd0);

        // Restart: timeout sticks through the discarded first rise
        push_a(6, 3, 0, 0);
        push_a(6, 3, 0, 6);
        gen_a(3, 3, 1);
        check("restart_timeout_sticky", 32'(timeout_a), 32'd1);
        gen_a(3, 3, 2);
        check("restart_timeout_cleared", 32'(timeout_a), 32'd0);
        en_a = 1'b0;
        tick(3);
        check("restart_queue_drained", q_a.size(), 32'd0);

        // 10/2 then switch to 4/1
        en_a = 1'b1;
        tick(3);
        push_a(10, 2, 0, 0);
        push_a(10, 2, 0, 10);
        push_a(10, 2, 0, 10);
        for (int i = 0; i < 3; i++) push_a(4, 1, 0, 4);
        gen_a(2, 8, 3);
        gen_a(1, 3, 4);
        en_a = 1'b0;
        tick(3);
        check("switch_queue_drained", q_a.size(), 32'd0);

        // en dropped mid-period on 8/4, then re-enabled
        en_a = 1'b1;
        tick(3);
        push_a(8, 4, 0, 0);
        push_a(8, 4, 0, 8);
        push_a(8, 4, 0, 8);
        gen_a(4, 4, 3);
        sig_a = 1'b1;
        tick(4);
        sig_a = 1'b0;
        tick(2);
        en_a = 1'b0;
        tick(2);
        gen_a(4, 4, 2);
        check("en_off_queue_drained", q_a.size(), 32'd0);
        check("en_off_period_hold", 32'(period_a), 32'd8);
        check("en_off_high_hold", 32'(high_a), 32'd4);
        en_a = 1'b1;
        push_a(8, 4, 0, 0);
        push_a(8, 4, 0, 8);
        gen_a(4, 4, 3);
        en_a = 1'b0;
        tick(3);
        check("reenable_queue_drained", q_a.size(), 32'd0);

        // Asynchronous reset pulse in the middle of a measurement
        en_a = 1'b1;
        tick(3);
        push_a(6, 3, 0, 0);
        push_a(6, 3, 0, 6);
        gen_a(3, 3, 2);
        sig_a = 1'b1;
        tick(3);
        sig_a = 1'b0;
        tick(1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_period", 32'(period_a), 32'd0);
        check("arst_high_time", 32'(high_a), 32'd0);
        check("arst_valid", 32'(valid_a), 32'd0);
        check("arst_timeout", 32'(timeout_a), 32'd0);
        rst_n = 1'b1;
        tick(1);
        check("arst_queue_drained", q_a.size(), 32'd0);
        tick(3);
        push_a(6, 3, 0, 0);
        push_a(6, 3, 0, 6);
        gen_a(3, 3, 3);
        en_a = 1'b0;
        tick(3);
        check("post_arst_queue_drained", q_a.size(), 32'd0);

        // TIMEOUT=6 with a period of exactly 6: the rise must win every time
        en_b = 1'b1;
        tick(3);
        push_b(6, 3, 0, 0);
        for (int i = 0; i < 3; i++) push_b(6, 3, 0, 6);
        guard_b = 1'b1;
        gen_b(3, 3, 5);
        guard_b = 1'b0;
        en_b = 1'b0;
        check("edge_timeout_never", to_seen_b, 32'd0);
        check("edge_timeout_final", 32'(timeout_b), 32'd0);
        tick(3);
        check("edge_queue_drained", q_b.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
